// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    localparam int unsigned DEF_AW = 10;
    localparam int unsigned DEF_DW = 32;
    localparam int unsigned DEF_BW = 4;

endpackage

// File: rtl/dmem_burst_ctr.sv
// Burst beat counter for the DMA port: latches base address, length and
// direction at burst start and produces the current beat address.
module dmem_burst_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned BW = DEF_BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          advance,
    input  logic [AW-1:0] start_addr,
    input  logic [BW-1:0] start_len,
    input  logic          start_we,
    output logic [AW-1:0] beat_addr,
    output logic          beat_we,
    output logic          last_beat
);

    logic [AW-1:0] base_q;
    logic [BW-1:0] len_q;
    logic [BW-1:0] cnt_q;
    logic          we_q;

    // Latch burst parameters on start; beat 0 is done by the start cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
        end else if (start) begin
            base_q <= start_addr;
            len_q  <= start_len;
            we_q   <= start_we;
            cnt_q  <= BW'(1);
        end else if (advance && !last_beat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sum is truncated to AW bits so the address wraps at the top of memory.
    assign beat_addr = base_q + AW'(cnt_q);
    assign beat_we   = we_q;
    assign last_beat = (cnt_q == len_q);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: core (port 0) single
// beats and DMA/debug (port 1) fixed-length bursts with auto-increment.
// Optional: define DMEM_ARB_FIXED_PRIO_EN to give port 0 fixed priority
// instead of round-robin arbitration in IDLE.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned BW = DEF_BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [BW-1:0] p1_len,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_done,
    output logic [AW-1:0] mem_A,
    output logic [DW-1:0] mem_Data,
    output logic          mem_W_en,
    input  logic [DW-1:0] mem_RD
);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] mem_a_q, mem_a_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          mem_we;
    logic          gnt0, gnt1;
    logic          rd0, rd1;
    logic          done_d, done_q;
    logic          p0_rvalid_q, p1_rvalid_q;
    logic [DW-1:0] p0_rdata_q, p1_rdata_q;
    logic          pick0;
    logic          burst_start, burst_adv;
    logic [AW-1:0] ctr_addr;
    logic          ctr_we;
    logic          ctr_last;

    dmem_burst_ctr #(
        .AW (AW),
        .BW (BW)
    ) u_burst_ctr (
        .clk        (clk),
        .rst        (rst),
        .start      (burst_start),
        .advance    (burst_adv),
        .start_addr (p1_addr),
        .start_len  (p1_len),
        .start_we   (p1_we),
        .beat_addr  (ctr_addr),
        .beat_we    (ctr_we),
        .last_beat  (ctr_last)
    );

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Core always wins contention.
    assign pick0 = p0_req;
`else
    logic last_q;

    // Remember which port was granted most recently for round-robin.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT_DMA;
        end else if (gnt0) begin
            last_q <= PORT_CORE;
        end else if (gnt1) begin
            last_q <= PORT_DMA;
        end
    end

    assign pick0 = p0_req && (!p1_req || (last_q == PORT_DMA));
`endif

    // Arbitration, burst sequencing and memory pin muxing. Grants are held off
    // while rst is high so a burst being abandoned writes nothing further.
    always_comb begin
        state_d     = state_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        rd0         = 1'b0;
        rd1         = 1'b0;
        done_d      = 1'b0;
        burst_start = 1'b0;
        burst_adv   = 1'b0;
        mem_a_d     = mem_a_q;
        mem_data_d  = mem_data_q;
        mem_we      = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick0) begin
                        gnt0       = 1'b1;
                        mem_a_d    = p0_addr;
                        mem_data_d = p0_wdata;
                        mem_we     = p0_we;
                        rd0        = !p0_we;
                    end else if (p1_req) begin
                        gnt1        = 1'b1;
                        burst_start = 1'b1;
                        mem_a_d     = p1_addr;
                        mem_data_d  = p1_wdata;
                        mem_we      = p1_we;
                        rd1         = !p1_we;
                        if (p1_len != '0) begin
                            state_d = ST_BURST;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    gnt1       = 1'b1;
                    burst_adv  = 1'b1;
                    mem_a_d    = ctr_addr;
                    mem_data_d = p1_wdata;
                    mem_we     = ctr_we;
                    rd1        = !ctr_we;
                    if (ctr_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, held memory pins, read-data capture and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_a_q     <= '0;
            mem_data_q  <= '0;
            done_q      <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_a_q     <= mem_a_d;
            mem_data_q  <= mem_data_d;
            done_q      <= done_d;
            p0_rvalid_q <= rd0;
            p1_rvalid_q <= rd1;
            if (rd0) begin
                p0_rdata_q <= mem_RD;
            end
            if (rd1) begin
                p1_rdata_q <= mem_RD;
            end
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p1_done   = done_q;
    assign mem_A     = mem_a_d;
    assign mem_Data  = mem_data_d;
    assign mem_W_en  = mem_we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1024x32 memory model attached.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we;
    logic [9:0]  p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_gnt, p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p1_req, p1_we;
    logic [9:0]  p1_addr;
    logic [3:0]  p1_len;
    logic [31:0] p1_wdata;
    logic        p1_gnt, p1_rvalid, p1_done;
    logic [31:0] p1_rdata;
    logic [9:0]  mem_A;
    logic [31:0] mem_Data;
    logic        mem_W_en;
    logic [31:0] mem_RD;

    logic [31:0] mem [1024] = '{default: 32'h0};

    int checks   = 0;
    int failures = 0;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_len    (p1_len),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p1_done   (p1_done),
        .mem_A     (mem_A),
        .mem_Data  (mem_Data),
        .mem_W_en  (mem_W_en),
        .mem_RD    (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_RD = mem[mem_A];
    always @(posedge clk) if (mem_W_en) mem[mem_A] <= mem_Data;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_len = '0; p1_wdata = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (p0_gnt !== 1'b0) begin failures++; $display("FAIL rst_p0_gnt got=%0b want=0", p0_gnt); end
        checks++; if (p1_gnt !== 1'b0) begin failures++; $display("FAIL rst_p1_gnt got=%0b want=0", p1_gnt); end
        checks++; if (p0_rvalid !== 1'b0) begin failures++; $display("FAIL rst_p0_rvalid got=%0b want=0", p0_rvalid); end
        checks++; if (p1_rvalid !== 1'b0) begin failures++; $display("FAIL rst_p1_rvalid got=%0b want=0", p1_rvalid); end
        checks++; if (p1_done !== 1'b0) begin failures++; $display("FAIL rst_p1_done got=%0b want=0", p1_done); end
        checks++; if (p0_rdata !== 32'h0) begin failures++; $display("FAIL rst_p0_rdata got=%h want=0", p0_rdata); end
        checks++; if (p1_rdata !== 32'h0) begin failures++; $display("FAIL rst_p1_rdata got=%h want=0", p1_rdata); end
        checks++; if (mem_A !== 10'd0) begin failures++; $display("FAIL rst_mem_A got=%0d want=0", mem_A); end
        checks++; if (mem_Data !== 32'h0) begin failures++; $display("FAIL rst_mem_Data got=%h want=0", mem_Data); end
        checks++; if (mem_W_en !== 1'b0) begin failures++; $display("FAIL rst_mem_W_en got=%0b want=0", mem_W_en); end
    endtask

    task automatic test_p0_basic();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'd5; p0_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL p0wr_gnt got=%0b want=1", p0_gnt); end
        checks++; if (mem_W_en !== 1'b1) begin failures++; $display("FAIL p0wr_we got=%0b want=1", mem_W_en); end
        checks++; if (mem_A !== 10'd5) begin failures++; $display("FAIL p0wr_addr got=%0d want=5", mem_A); end
        checks++; if (mem_Data !== 32'hDEADBEEF) begin failures++; $display("FAIL p0wr_data got=%h want=deadbeef", mem_Data); end
        step();
        p0_we = 1'b0;
        #1;
        checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL p0rd_gnt got=%0b want=1", p0_gnt); end
        checks++; if (p0_rvalid !== 1'b0) begin failures++; $display("FAIL p0wr_no_rvalid got=%0b want=0", p0_rvalid); end
        checks++; if (mem_W_en !== 1'b0) begin failures++; $display("FAIL p0rd_we got=%0b want=0", mem_W_en); end
        step();
        p0_req = 1'b0;
        #1;
        checks++; if (p0_rvalid !== 1'b1) begin failures++; $display("FAIL p0rd_rvalid got=%0b want=1", p0_rvalid); end
        checks++; if (p0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL p0rd_rdata got=%h want=deadbeef", p0_rdata); end
        checks++; if (mem_A !== 10'd5) begin failures++; $display("FAIL idle_hold_addr got=%0d want=5", mem_A); end
        step();
        checks++; if (p0_rvalid !== 1'b0) begin failures++; $display("FAIL p0rd_rvalid_once got=%0b want=0", p0_rvalid); end
    endtask

    task automatic test_round_robin();
        logic exp0;
        do_reset();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'd5;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'd5; p1_len = 4'd0;
        for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp0 = 1'b1;
`else
            exp0 = (i % 2 == 0);
`endif
            #1;
            checks++; if (p0_gnt !== exp0) begin failures++; $display("FAIL rr_p0_gnt[%0d] got=%0b want=%0b", i, p0_gnt, exp0); end
            checks++; if (p1_gnt !== !exp0) begin failures++; $display("FAIL rr_p1_gnt[%0d] got=%0b want=%0b", i, p1_gnt, !exp0); end
            step();
        end
        p0_req = 1'b0; p1_req = 1'b0;
        step();
    endtask

    task automatic test_write_burst();
        logic [9:0] exp_a [4];
        exp_a = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        do_reset();
        // One core access first so the DMA port wins the next contest.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'd100;
        #1;
        checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL wb_pre_gnt got=%0b want=1", p0_gnt); end
        step();
`ifdef DMEM_ARB_FIXED_PRIO_EN
        p0_req = 1'b0;
`endif
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 10'd1022; p1_len = 4'd3;
        for (int i = 0; i < 4; i++) begin
            p1_wdata = 32'(i + 1);
            #1;
            checks++; if (p1_gnt !== 1'b1) begin failures++; $display("FAIL wb_p1_gnt[%0d] got=%0b want=1", i, p1_gnt); end
            checks++; if (p0_gnt !== 1'b0) begin failures++; $display("FAIL wb_p0_stall[%0d] got=%0b want=0", i, p0_gnt); end
            checks++; if (mem_A !== exp_a[i]) begin failures++; $display("FAIL wb_addr[%0d] got=%0d want=%0d", i, mem_A, exp_a[i]); end
            checks++; if (mem_W_en !== 1'b1) begin failures++; $display("FAIL wb_we[%0d] got=%0b want=1", i, mem_W_en); end
            checks++; if (mem_Data !== 32'(i + 1)) begin failures++; $display("FAIL wb_data[%0d] got=%0d want=%0d", i, mem_Data, i + 1); end
            checks++; if (p1_done !== 1'b0) begin failures++; $display("FAIL wb_done_early[%0d] got=%0b want=0", i, p1_done); end
            step();
            p1_req = 1'b0;
            p0_req = 1'b1;
        end
        #1;
        checks++; if (p1_done !== 1'b1) begin failures++; $display("FAIL wb_done got=%0b want=1", p1_done); end
        checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL wb_p0_after got=%0b want=1", p0_gnt); end
        checks++; if (p1_gnt !== 1'b0) begin failures++; $display("FAIL wb_p1_after got=%0b want=0", p1_gnt); end
        step();
        p0_req = 1'b0;
        #1;
        checks++; if (p1_done !== 1'b0) begin failures++; $display("FAIL wb_done_once got=%0b want=0", p1_done); end
        checks++; if (mem[1022] !== 32'd1) begin failures++; $display("FAIL wb_mem1022 got=%0d want=1", mem[1022]); end
        checks++; if (mem[1023] !== 32'd2) begin failures++; $display("FAIL wb_mem1023 got=%0d want=2", mem[1023]); end
        checks++; if (mem[0] !== 32'd3) begin failures++; $display("FAIL wb_mem0 got=%0d want=3", mem[0]); end
        checks++; if (mem[1] !== 32'd4) begin failures++; $display("FAIL wb_mem1 got=%0d want=4", mem[1]); end
    endtask

    task automatic test_read_burst();
        // Last grant went to the core, so the DMA port wins if both ask.
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'd1022; p1_len = 4'd2;
        p0_we = 1'b0; p0_addr = 10'd0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        p0_req = 1'b0;
`else
        p0_req = 1'b1;
`endif
        #1;
        checks++; if (p1_gnt !== 1'b1) begin failures++; $display("FAIL rb_gnt0 got=%0b want=1", p1_gnt); end
        checks++; if (mem_A !== 10'd1022) begin failures++; $display("FAIL rb_addr0 got=%0d want=1022", mem_A); end
        step();
        p1_req = 1'b0; p0_req = 1'b1;
        #1;
        checks++; if (mem_A !== 10'd1023) begin failures++; $display("FAIL rb_addr1 got=%0d want=1023", mem_A); end
        checks++; if (p1_rvalid !== 1'b1) begin failures++; $display("FAIL rb_rvalid1 got=%0b want=1", p1_rvalid); end
        checks++; if (p1_rdata !== 32'd1) begin failures++; $display("FAIL rb_rdata1 got=%0d want=1", p1_rdata); end
        step();
        checks++; if (p0_gnt !== 1'b0) begin failures++; $display("FAIL rb_p0_stall got=%0b want=0", p0_gnt); end
        checks++; if (mem_A !== 10'd0) begin failures++; $display("FAIL rb_addr2 got=%0d want=0", mem_A); end
        checks++; if (p1_rdata !== 32'd2) begin failures++; $display("FAIL rb_rdata2 got=%0d want=2", p1_rdata); end
        step();
        checks++; if (p1_rvalid !== 1'b1) begin failures++; $display("FAIL rb_rvalid3 got=%0b want=1", p1_rvalid); end
        checks++; if (p1_rdata !== 32'd3) begin failures++; $display("FAIL rb_rdata3 got=%0d want=3", p1_rdata); end
        checks++; if (p1_done !== 1'b1) begin failures++; $display("FAIL rb_done got=%0b want=1", p1_done); end
        checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL rb_p0_gnt got=%0b want=1", p0_gnt); end
        step();
        p0_req = 1'b0;
        #1;
        checks++; if (p0_rvalid !== 1'b1) begin failures++; $display("FAIL rb_p0_rvalid got=%0b want=1", p0_rvalid); end
        checks++; if (p0_rdata !== 32'd3) begin failures++; $display("FAIL rb_p0_rdata got=%0d want=3", p0_rdata); end
        checks++; if (p1_rvalid !== 1'b0) begin failures++; $display("FAIL rb_rvalid_end got=%0b want=0", p1_rvalid); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 10'd200; p1_len = 4'd7; p1_wdata = 32'hA0;
        #1;
        checks++; if (p1_gnt !== 1'b1) begin failures++; $display("FAIL rm_gnt got=%0b want=1", p1_gnt); end
        step();
        p1_req = 1'b0; p1_wdata = 32'hA1;
        step();
        rst = 1'b1; p1_wdata = 32'hA2;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (p1_gnt !== 1'b0) begin failures++; $display("FAIL rm_p1_gnt got=%0b want=0", p1_gnt); end
        checks++; if (mem_W_en !== 1'b0) begin failures++; $display("FAIL rm_we got=%0b want=0", mem_W_en); end
        checks++; if (mem_A !== 10'd0) begin failures++; $display("FAIL rm_addr got=%0d want=0", mem_A); end
        checks++; if (mem_Data !== 32'h0) begin failures++; $display("FAIL rm_data got=%h want=0", mem_Data); end
        checks++; if (p1_done !== 1'b0) begin failures++; $display("FAIL rm_done got=%0b want=0", p1_done); end
        step();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'd200;
        #1;
        checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL rm_idle_p0_gnt got=%0b want=1", p0_gnt); end
        step();
        p0_req = 1'b0;
        #1;
        checks++; if (p0_rdata !== 32'hA0) begin failures++; $display("FAIL rm_rdata got=%h want=a0", p0_rdata); end
        checks++; if (mem[201] !== 32'hA1) begin failures++; $display("FAIL rm_mem201 got=%h want=a1", mem[201]); end
        for (int a = 203; a < 208; a++) begin
            checks++; if (mem[a] !== 32'h0) begin failures++; $display("FAIL rm_nowrite[%0d] got=%h want=0", a, mem[a]); end
        end
    endtask

    task automatic test_contention_same_addr();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'd300; p0_wdata = 32'h1111;
        step();
        do_reset();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'd300;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 10'd300; p1_len = 4'd0; p1_wdata = 32'h2222;
        #1;
        checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL ct_p0_gnt got=%0b want=1", p0_gnt); end
        checks++; if (p1_gnt !== 1'b0) begin failures++; $display("FAIL ct_p1_wait got=%0b want=0", p1_gnt); end
        checks++; if (mem_W_en !== 1'b0) begin failures++; $display("FAIL ct_we0 got=%0b want=0", mem_W_en); end
        step();
        p0_req = 1'b0;
        #1;
        checks++; if (p1_gnt !== 1'b1) begin failures++; $display("FAIL ct_p1_gnt got=%0b want=1", p1_gnt); end
        checks++; if (mem_W_en !== 1'b1) begin failures++; $display("FAIL ct_we1 got=%0b want=1", mem_W_en); end
        checks++; if (p0_rvalid !== 1'b1) begin failures++; $display("FAIL ct_rvalid got=%0b want=1", p0_rvalid); end
        checks++; if (p0_rdata !== 32'h1111) begin failures++; $display("FAIL ct_old_data got=%h want=1111", p0_rdata); end
        step();
        p1_req = 1'b0;
        #1;
        checks++; if (p1_done !== 1'b1) begin failures++; $display("FAIL ct_done got=%0b want=1", p1_done); end
        checks++; if (mem[300] !== 32'h2222) begin failures++; $display("FAIL ct_mem got=%h want=2222", mem[300]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_p0_basic();
        test_round_robin();
        test_write_burst();
        test_read_burst();
        test_reset_mid_burst();
        test_contention_same_addr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory (1024 × 32, asynchronous read, synchronous write) between two requesters: port 0, the core load/store unit, and port 1, a DMA/debug master. Port 1 may issue fixed-length bursts with address auto-increment. Arbitration is round-robin by default. The block drives the memory's address, write-data and write-enable pins and returns registered read data to the winning requester.

## Interface
Parameters:
- AW, 10, word address width.
- DW, 32, data width.
- BW, 4, burst length field width; max burst = 2^BW beats.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  core access request, single beat.
- p0_we  in  1  1 = write, 0 = read.
- p0_addr  in  AW  word address.
- p0_wdata  in  DW  write data.
- p0_gnt  out  1  access performed this cycle; core stalls while req & !gnt.
- p0_rvalid  out  1  read data valid, one cycle after a granted read.
- p0_rdata  out  DW  registered read data.
- p1_req  in  1  DMA request; sampled only in IDLE.
- p1_we  in  1  burst direction; latched at burst start.
- p1_addr  in  AW  burst start address; latched at burst start.
- p1_len  in  BW  beats minus one (0 = single beat).
- p1_wdata  in  DW  write data, consumed on every cycle p1_gnt = 1.
- p1_gnt  out  1  one beat performed this cycle.
- p1_rvalid  out  1  read beat valid, one cycle after the granted read beat.
- p1_rdata  out  DW  registered read data.
- p1_done  out  1  one-cycle pulse, the cycle after the last beat.
- mem_A  out  AW  to memory address.
- mem_Data  out  DW  to memory write data.
- mem_W_en  out  1  to memory write enable.
- mem_RD  in  DW  from memory asynchronous read data.

## Operation
- States: IDLE, BURST.
- IDLE arbitration, combinational, same cycle:
  - Only one requester asserts req: it wins.
  - Both assert req: the port not granted last wins.
  - `last` resets to 1, so port 0 wins the first contest.
  - `last` updates on every grant.
- Port 0 grant:
  - mem_A = p0_addr; mem_Data = p0_wdata; mem_W_en = p0_we.
- Port 1 grant in IDLE:
  - Performs beat 0 at p1_addr.
  - Latches base, we and len; beat counter ← 1.
  - If p1_len ≠ 0, the next state is BURST. Otherwise p1_done pulses next cycle.
- BURST:
  - p1_gnt = 1 every cycle; p0_gnt = 0.
  - mem_A = base + cnt, truncated to AW bits, so the address wraps 1023 → 0.
  - mem_W_en = latched we. p1_req and p1_len are ignored.
  - When cnt == len: return to IDLE and pulse p1_done next cycle. Otherwise cnt increments.
- No grant: mem_W_en = 0; mem_A and mem_Data hold their last values.
- Read data: on a granted read, p*_rdata ← mem_RD at the clock edge, and p*_rvalid = 1 in the following cycle only. Granted writes produce no rvalid.
- Bursts cannot be aborted. Only rst terminates them.

## Timing
- Grant is combinational from req in IDLE; write latency is 0 (memory samples on the same edge).
- Read latency is 1 cycle, from grant to rvalid.
- Port 0 worst-case wait: 2^BW + 1 cycles.
- Back-to-back: a port 1 burst finishing in cycle N allows a port 0 grant in cycle N+1 (IDLE).
- Reset values: state = IDLE, cnt = 0, last = 1, all gnt/rvalid/done = 0, rdata = 0, mem_W_en = 0, mem_A = 0, mem_Data = 0.
- rst asserted mid-burst: the burst is abandoned at the next edge, with no further writes. rst does not clear memory contents.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN:
  - Defined: port 0 always wins contention in IDLE, and `last` is not used.
  - Undefined: round-robin as described above.
- Burst behaviour is identical in both modes.

## Structure
- Package dmem_arb_pkg:
  - State enum (ST_IDLE, ST_BURST).
  - Port index constants (PORT_CORE = 0, PORT_DMA = 1).
  - Default AW/DW/BW.
- Sub-module dmem_burst_ctr: latches base/len, produces the beat address and the last-beat flag; this is the natural split.
- Arbitration and muxing remain in dmem_arbiter.

## Test plan
- After reset, a p0 write of 0xDEADBEEF to 5, then a p0 read of 5 → p0_gnt same cycle, p0_rvalid next cycle with 0xDEADBEEF.
- p0_req and p1_req (single beat) asserted every cycle → grants alternate 0, 1, 0, 1; with DMEM_ARB_FIXED_PRIO_EN, p0 is granted always.
- p1 write burst: addr 1022, len 3, data 1..4 → writes land at 1022, 1023, 0, 1; p1_done pulses once; p0 is stalled for 4 cycles.
- p1 read burst of len 2 over the previous data, with p0_req held → 3 p1_rvalid beats in order, then p0 granted the cycle after the last beat.
- rst asserted during beat 2 of a len 7 write burst → no writes after reset; state IDLE; all outputs at reset values.
- Simultaneous p0 read and p1 write to the same address in IDLE with last = 1 → p0 wins and reads the old data; p1 is granted next cycle.
